// File: rtl/exe_muldiv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : exe_muldiv
// Brief    : Iterative 32-cycle multiply/divide unit for the EXE stage.
//            MULDIV_SIGNED_EN enables signed MULT/DIV; otherwise op[0] is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module exe_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             stall_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [5:0] c_LAST_ITER = 6'd31;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [5:0]       r_cnt;
    logic             r_done;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_hi_out;
    logic [WIDTH-1:0] r_lo_out;

    logic             w_accept;
    logic             w_sgn_a;
    logic             w_sgn_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_sh;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign hi_out    = r_hi_out;
    assign lo_out    = r_lo_out;
    // The completing instruction is still presented during the done cycle.
    assign w_accept  = (r_state == S_IDLE) && start && !r_done;
    assign stall_out = busy || w_accept;

`ifdef MULDIV_SIGNED_EN
    assign w_sgn_a = op[0] & src_a[WIDTH-1];
    assign w_sgn_b = op[0] & src_b[WIDTH-1];
    assign w_abs_a = w_sgn_a ? -src_a : src_a;
    assign w_abs_b = w_sgn_b ? -src_b : src_b;
`else
    logic w_unused_op0;
    assign w_unused_op0 = op[0];
    assign w_sgn_a      = 1'b0;
    assign w_sgn_b      = 1'b0;
    assign w_abs_a      = src_a;
    assign w_abs_b      = src_b;
`endif

    // Multiply: {r_hi, r_lo} shifts right, r_lo starts as the multiplier.
    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    // Divide: r_hi holds the partial remainder, r_lo shifts dividend out/quotient in.
    assign w_div_sh   = {r_hi, r_lo[WIDTH-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_opb};
    assign w_div_ok   = !w_div_diff[WIDTH];

`ifdef MULDIV_SIGNED_EN
    logic [2*WIDTH-1:0] w_prod_fix;
    assign w_prod_fix = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_res_lo   = r_is_div ? (r_neg_q ? -r_lo : r_lo) : w_prod_fix[WIDTH-1:0];
    assign w_res_hi   = r_is_div ? (r_neg_r ? -r_hi : r_hi) : w_prod_fix[2*WIDTH-1:WIDTH];
`else
    logic w_unused_neg;
    assign w_unused_neg = r_neg_q ^ r_neg_r;
    assign w_res_lo     = r_lo;
    assign w_res_hi     = r_hi;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) w_state_nxt = S_CALC;
                S_CALC:  if (r_cnt == c_LAST_ITER) w_state_nxt = S_FIX;
                S_FIX:   w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opb    <= '0;
            r_hi_out <= '0;
            r_lo_out <= '0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_cnt    <= '0;
                            r_is_div <= op[1];
                            r_neg_q  <= w_sgn_a ^ w_sgn_b;
                            r_neg_r  <= w_sgn_a;
                            r_hi     <= '0;
                            r_lo     <= op[1] ? w_abs_a : w_abs_b;
                            r_opb    <= op[1] ? w_abs_b : w_abs_a;
                        end
                    end
                    S_CALC: begin
                        r_cnt <= r_cnt + 6'd1;
                        if (r_is_div) begin
                            r_hi <= w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
                            r_lo <= {r_lo[WIDTH-2:0], w_div_ok};
                        end else begin
                            r_hi <= w_mul_sum[WIDTH:1];
                            r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                        end
                    end
                    S_FIX: begin
                        r_hi_out <= w_res_hi;
                        r_lo_out <= w_res_lo;
                        r_done   <= 1'b1;
                    end
                    default: r_cnt <= '0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exe_muldiv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_exe_muldiv
// Brief    : Directed self-checking bench for exe_muldiv (both MULDIV_SIGNED_EN builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_muldiv;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        stall_out;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_checks = 0;
    int n_errors = 0;

    exe_muldiv #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .stall_out (stall_out),
        .busy      (busy),
        .done      (done),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one operation from a falling edge, scrambles operands after acceptance,
    // and returns once done is seen (bounded).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output int lat);
        op = o; src_a = a; src_b = b; start = 1'b1;
        stalls = 0;
        lat = 0;
        while (!done && lat < 100) begin
            #1;
            if (stall_out) stalls++;
            @(negedge clock);
            lat++;
            if (lat == 2) begin
                src_a = ~a;
                src_b = b ^ 32'h5;
                op    = ~o;
            end
        end
    endtask

    // Checks the done cycle (start still high) and the cycle after it.
    task automatic close_op(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                            input int stalls, input int lat);
        check({tag, ".hi"}, {32'h0, hi_out}, {32'h0, exp_hi});
        check({tag, ".lo"}, {32'h0, lo_out}, {32'h0, exp_lo});
        check({tag, ".latency"}, 64'(lat), 64'd34);
        check({tag, ".stall_cycles"}, 64'(stalls), 64'd34);
        check({tag, ".done_hi"}, {63'h0, done}, 64'd1);
        check({tag, ".stall_in_done"}, {63'h0, stall_out}, 64'd0);
        @(negedge clock);
        check({tag, ".done_one_cycle"}, {63'h0, done}, 64'd0);
        check({tag, ".no_retrigger"}, {63'h0, busy}, 64'd0);
        start = 1'b0;
    endtask

    initial begin
        int st;
        int lt;
        int done_seen;
        reset = 1'b0; flush = 1'b0; start = 1'b0;
        op = 2'b00; src_a = '0; src_b = '0;
        repeat (2) @(negedge clock);
        check("rst.hi", {32'h0, hi_out}, 64'h0);
        check("rst.lo", {32'h0, lo_out}, 64'h0);
        check("rst.busy", {63'h0, busy}, 64'h0);
        check("rst.done", {63'h0, done}, 64'h0);
        reset = 1'b1;
        @(negedge clock);
        check("idle.stall", {63'h0, stall_out}, 64'h0);

        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, st, lt);
        close_op("multu_max", 32'hFFFFFFFE, 32'h00000001, st, lt);

`ifdef MULDIV_SIGNED_EN
        run_op(2'b11, 32'hFFFFFFF9, 32'h2, st, lt);
        close_op("div_m7_2", 32'hFFFFFFFF, 32'hFFFFFFFD, st, lt);
`else
        run_op(2'b11, 32'h7, 32'h2, st, lt);
        close_op("div_7_2", 32'h1, 32'h3, st, lt);
`endif

        run_op(2'b10, 32'h12345678, 32'h0, st, lt);
        close_op("divu_by0", 32'h12345678, 32'hFFFFFFFF, st, lt);

        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, st, lt);
`ifdef MULDIV_SIGNED_EN
        close_op("div_ovf", 32'h0, 32'h80000000, st, lt);
`else
        close_op("div_ovf", 32'h80000000, 32'h0, st, lt);
`endif

        run_op(2'b01, 32'hFFFFFFFD, 32'h5, st, lt);
`ifdef MULDIV_SIGNED_EN
        close_op("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFF1, st, lt);
`else
        close_op("mult_neg", 32'h4, 32'hFFFFFFF1, st, lt);
`endif

        run_op(2'b10, 32'd100, 32'd7, st, lt);
        close_op("divu_100_7", 32'd2, 32'd14, st, lt);

        // Flush at cycle 10 of MULT 3*5: results stay at 2/14, no done.
        op = 2'b01; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
        repeat (10) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0; start = 1'b0;
        check("flush.busy", {63'h0, busy}, 64'h0);
        check("flush.hi", {32'h0, hi_out}, 64'd2);
        check("flush.lo", {32'h0, lo_out}, 64'd14);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) done_seen++;
        end
        check("flush.no_done", 64'(done_seen), 64'd0);

        run_op(2'b00, 32'd6, 32'd7, st, lt);
        close_op("multu_6_7", 32'd0, 32'd42, st, lt);

        // Flush has priority over a simultaneous start.
        op = 2'b00; src_a = 32'd9; src_b = 32'd9; start = 1'b1; flush = 1'b1;
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        check("flush_start.busy", {63'h0, busy}, 64'h0);

        // Reset pulsed at cycle 20 of a DIVU.
        op = 2'b10; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        repeat (20) @(negedge clock);
        check("pre_rst.busy", {63'h0, busy}, 64'h1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst.busy", {63'h0, busy}, 64'h0);
        check("mid_rst.hi", {32'h0, hi_out}, 64'h0);
        check("mid_rst.lo", {32'h0, lo_out}, 64'h0);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst.done", {63'h0, done}, 64'h0);

        run_op(2'b10, 32'd1000, 32'd3, st, lt);
        close_op("divu_1000_3", 32'd1, 32'd333, st, lt);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exe_muldiv.md
EXE_MULDIV -- requirements
Module: exe_muldiv

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 Port: clock  input  1  rising-edge clock, the block's only clock.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: flush  input  1  active-high abort of the EXE-stage instruction, sampled at the rising edge.
REQ-005 Port: start  input  1  EXE-stage instruction is a mul/div (decoded from the ID/EXE alu_op_out).
REQ-006 Port: op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 Port: src_a  input  32  operand A (ID/EXE gpr_a_out, forwarded); multiplicand or dividend.
REQ-008 Port: src_b  input  32  operand B (ID/EXE gpr_b_out, forwarded); multiplier or divisor.
REQ-009 Port: stall_out  output  1  combinational hold request to the PC, IF/ID and ID/EXE registers.
REQ-010 Port: busy  output  1  high while an operation is in progress.
REQ-011 Port: done  output  1  one-cycle pulse when hi_out/lo_out update.
REQ-012 Port: hi_out  output  32  HI register (product high word or remainder).
REQ-013 Port: lo_out  output  32  LO register (product low word or quotient).

Function
REQ-014 The block SHALL implement a FSM with states IDLE, CALC and FIX; busy SHALL equal (state != IDLE).
REQ-015 In IDLE with done low, start high at rising edge E0 SHALL do the following, then enter CALC: latch op and operand magnitudes (absolute values for signed ops), and clear the 6-bit iteration counter.
REQ-016 CALC SHALL process one bit per cycle, using radix-2 shift-add for multiply and restoring shift-subtract for divide, and SHALL enter FIX after exactly 32 cycles (counter 0..31).
REQ-017 FIX SHALL last one cycle, apply sign correction, write hi_out/lo_out, assert done for the following cycle and return to IDLE; the result appears at edge E0+33.
REQ-018 stall_out SHALL equal busy OR (start AND state==IDLE AND NOT done), so it is high for 34 cycles per operation.
REQ-019 While done is high, start SHALL be ignored, because it is the completing instruction still presented, and stall_out SHALL be low so that instruction advances.
REQ-020 MULT/MULTU SHALL place the 64-bit product with {hi_out, lo_out} = product.
REQ-021 DIV/DIVU SHALL place the quotient in lo_out and the remainder in hi_out.
REQ-022 Signed divide SHALL give a quotient negated iff the sign of A differs from the sign of B, and a remainder carrying the sign of A.
REQ-023 Divide by zero SHALL give lo_out=32'hFFFFFFFF and hi_out=|A|, with the signed correction of REQ-022 applied; no exception is raised.
REQ-024 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give lo_out=32'h80000000 and hi_out=0.
REQ-025 flush high at any edge SHALL force IDLE, clear the counter and done, and leave hi_out/lo_out unchanged.
REQ-026 flush SHALL take priority over a simultaneous start and over FIX completion.
REQ-027 src_a, src_b and op SHALL be sampled only at the accepting edge; later changes SHALL have no effect.

Reset
REQ-028 reset low SHALL asynchronously force the state to IDLE and clear the counter, hi_out, lo_out, done and all datapath registers to 0.
REQ-029 After reset the state SHALL be IDLE and busy and stall_out SHALL be 0 unless start is high.
REQ-030 Reset asserted mid-operation SHALL discard the operation with no hi_out/lo_out update.

Configuration
REQ-031 With MULDIV_SIGNED_EN defined, MULT and DIV SHALL be signed as specified in REQ-022 to REQ-024.
REQ-032 Without MULDIV_SIGNED_EN, the sign-correction logic SHALL be omitted and op[0] ignored, so MULT behaves as MULTU and DIV as DIVU; latency is unchanged.

Verification
REQ-033 MULTU of A=32'hFFFFFFFF and B=32'hFFFFFFFF SHALL give hi_out=32'hFFFFFFFE and lo_out=32'h00000001, with done one cycle at E0+33 and stall_out high for 34 cycles.
REQ-034 DIV of A=-7 and B=2 (MULDIV_SIGNED_EN defined) SHALL give lo_out=32'hFFFFFFFD and hi_out=32'hFFFFFFFF; without the macro, DIV of A=7 and B=2 SHALL give lo_out=3 and hi_out=1.
REQ-035 DIVU of A=32'h12345678 and B=0 SHALL give lo_out=32'hFFFFFFFF and hi_out=32'h12345678.
REQ-036 MULT of 3 by 5 with flush at cycle 10 SHALL return to IDLE with hi_out/lo_out holding prior values and no done pulse; a following MULTU of 6 by 7 SHALL give lo_out=42.
REQ-037 reset pulsed low at cycle 20 of a DIVU SHALL immediately force busy=0 and hi_out=lo_out=0; start held through the done cycle SHALL not retrigger the operation.
